// File: rtl/spike_pkg.sv
// Shared spike/AER definitions used by the neuron array and the AER encoder.
// The event word packs {timestamp, neuron address} with the timestamp in the upper bits.
package spike_pkg;

  localparam int N_NEURONS  = 8;
  localparam int ADDR_W     = 3;
  localparam int TS_W       = 5;
  localparam int FIFO_DEPTH = 8;
  localparam int EV_W       = TS_W + ADDR_W;

  typedef struct packed {
    logic [TS_W-1:0]   ts;
    logic [ADDR_W-1:0] addr;
  } aer_event_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

  // Index of the lowest set bit; ascending address order within a frame.
  function automatic logic [ADDR_W-1:0] lowest_set(input logic [N_NEURONS-1:0] v);
    logic [ADDR_W-1:0] idx;
    idx = '0;
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = ADDR_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/aer_fifo.sv
// Show-ahead event FIFO: DEPTH-entry storage ring followed by a registered output stage.
// The output register holds its last value when the FIFO drains.
module aer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             push_ok,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [WIDTH-1:0] rd_data,
  output logic             nonempty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] out_r;
  logic             out_valid_r;
  logic             mem_empty_s;
  logic             mem_full_s;
  logic             load_s;
  logic             wr_en_s;

  assign mem_empty_s = (cnt_r == '0);
  assign mem_full_s  = (cnt_r == FULL_CNT);
  // The output stage refills whenever it is empty or being consumed this cycle.
  assign load_s      = !mem_empty_s && (!out_valid_r || rd_ready);
  assign push_ok     = !mem_full_s || load_s;
  assign wr_en_s     = push && push_ok;
  assign rd_valid    = out_valid_r;
  assign rd_data     = out_r;
  assign nonempty    = out_valid_r || !mem_empty_s;

  // Storage ring write port.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers, occupancy and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      cnt_r       <= '0;
      out_r       <= '0;
      out_valid_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (load_s) begin
        rd_ptr_r    <= rd_ptr_r + AW'(1);
        out_r       <= mem_r[rd_ptr_r];
        out_valid_r <= 1'b1;
      end else if (rd_ready) begin
        out_valid_r <= 1'b0;
      end
      case ({wr_en_s, load_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/spike_aer_encoder.sv
// Serialises per-cycle spike vectors into {timestamp, address} events over a valid/ready
// stream, counting frames lost while the scanner is still busy with an earlier frame.
module spike_aer_encoder
  import spike_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_NEURONS-1:0] spike_in,
  input  logic                 spike_valid,
  output logic [ADDR_W-1:0]    ev_addr,
  output logic [TS_W-1:0]      ev_ts,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic                 busy,
  output logic [7:0]           drop_cnt,
  output logic                 overflow
);

  scan_state_t          state_r, state_n;
  logic [N_NEURONS-1:0] pend_r, pend_n;
  logic [N_NEURONS-1:0] pend_clr_s;
  logic [TS_W-1:0]      ts_r, ts_n;
  logic [TS_W-1:0]      frame_cnt_r;
  logic [7:0]           drop_cnt_r;
  logic                 overflow_r;
  logic                 drop_s;
  logic                 last_s;
  logic                 push_ok_s;
  logic                 fifo_nonempty_s;
  logic [EV_W-1:0]      fifo_rd_data_s;
  aer_event_t           ev_word_s;
  aer_event_t           head_s;

  assign pend_clr_s = pend_r & (pend_r - N_NEURONS'(1));
  assign last_s     = (pend_clr_s == '0);
  assign ev_word_s  = '{ts: ts_r, addr: lowest_set(pend_r)};

  aer_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (state_r == ST_SCAN),
    .wdata    (ev_word_s),
    .push_ok  (push_ok_s),
    .rd_ready (ev_ready),
    .rd_valid (ev_valid),
    .rd_data  (fifo_rd_data_s),
    .nonempty (fifo_nonempty_s)
  );

  assign head_s   = fifo_rd_data_s;
  assign ev_addr  = head_s.addr;
  assign ev_ts    = head_s.ts;
  assign busy     = (state_r == ST_SCAN) || fifo_nonempty_s;
  assign drop_cnt = drop_cnt_r;
  assign overflow = overflow_r;

  // Next-state: capture in IDLE or on the final push of a scan; drop otherwise while scanning.
  always_comb begin
    state_n = state_r;
    pend_n  = pend_r;
    ts_n    = ts_r;
    drop_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (spike_valid && (spike_in != '0)) begin
          pend_n  = spike_in;
          ts_n    = frame_cnt_r;
          state_n = ST_SCAN;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (push_ok_s) begin
          pend_n = pend_clr_s;
          if (!last_s) begin
            drop_s = spike_valid;
          end else if (spike_valid && (spike_in != '0)) begin
            pend_n = spike_in;
            ts_n   = frame_cnt_r;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          drop_s = spike_valid;
        end
      end
      default: begin
        state_n = ST_IDLE;
        pend_n  = '0;
      end
    endcase
  end

  // State, pending vector, frame counter and drop bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      pend_r      <= '0;
      ts_r        <= '0;
      frame_cnt_r <= '0;
      drop_cnt_r  <= 8'd0;
      overflow_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      pend_r  <= pend_n;
      ts_r    <= ts_n;
      if (spike_valid) begin
        frame_cnt_r <= frame_cnt_r + TS_W'(1);
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (drop_cnt_r != 8'hFF) begin
          drop_cnt_r <= drop_cnt_r + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Scenario bench for spike_aer_encoder: expected events are queued as frames are driven
// and compared as the stream hands them over.
module tb_spike_aer_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] spike_in;
  logic       spike_valid;
  logic [2:0] ev_addr;
  logic [4:0] ev_ts;
  logic       ev_valid;
  logic       ev_ready;
  logic       busy;
  logic [7:0] drop_cnt;
  logic       overflow;

  logic [7:0] sb_q[$];
  logic [7:0] exp_w;
  int tests_run = 0;
  int tests_failed = 0;

  spike_aer_encoder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .spike_in    (spike_in),
    .spike_valid (spike_valid),
    .ev_addr     (ev_addr),
    .ev_ts       (ev_ts),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .busy        (busy),
    .drop_cnt    (drop_cnt),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_n = 1'b0;
    spike_valid = 1'b0;
    spike_in = 8'h00;
    ev_ready = 1'b0;
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++;
    if ({ev_addr, ev_ts, ev_valid, busy, drop_cnt, overflow} !== 19'd0) begin
      tests_failed++;
      $display("FAIL reset_state got addr=%0d ts=%0d v=%0b busy=%0b drop=%0d ovf=%0b want all 0",
               ev_addr, ev_ts, ev_valid, busy, drop_cnt, overflow);
    end
    ev_ready = 1'b0;
    spike_in = 8'hFF; spike_valid = 1'b1;
    @(negedge clk);
    spike_valid = 1'b0; spike_in = 8'h00;
    repeat (3) @(negedge clk);
    tests_run++;
    if (ev_valid !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_prefill got v=%0b busy=%0b want v=1 busy=1", ev_valid, busy);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({ev_addr, ev_ts, ev_valid, busy, drop_cnt, overflow} !== 19'd0) begin
      tests_failed++;
      $display("FAIL reset_async got addr=%0d ts=%0d v=%0b busy=%0b drop=%0d ovf=%0b want all 0",
               ev_addr, ev_ts, ev_valid, busy, drop_cnt, overflow);
    end
    @(negedge clk);
    tests_run++;
    if ({ev_addr, ev_ts, ev_valid, busy, drop_cnt, overflow} !== 19'd0) begin
      tests_failed++;
      $display("FAIL reset_hold got addr=%0d ts=%0d v=%0b busy=%0b want all 0",
               ev_addr, ev_ts, ev_valid, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    ev_ready = 1'b1;
    spike_in = 8'h01; spike_valid = 1'b1;
    sb_q.push_back({5'd0, 3'd0});
    @(negedge clk);
    spike_valid = 1'b0; spike_in = 8'h00;
    for (int c = 0; c < 20; c++) begin
      if (sb_q.size() == 0) break;
      if (ev_valid && ev_ready) begin
        exp_w = sb_q.pop_front();
        tests_run++;
        if ({ev_ts, ev_addr} !== exp_w) begin
          tests_failed++;
          $display("FAIL reset_event got ts=%0d addr=%0d want ts=%0d addr=%0d",
                   ev_ts, ev_addr, exp_w[7:3], exp_w[2:0]);
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL reset_timeout got %0d pending want 0", sb_q.size());
    end
  endtask

  task automatic test_single_frame();
    apply_reset();
    ev_ready = 1'b1;
    spike_in = 8'b1010_0100; spike_valid = 1'b1;
    sb_q.push_back({5'd0, 3'd2});
    sb_q.push_back({5'd0, 3'd5});
    sb_q.push_back({5'd0, 3'd7});
    @(negedge clk);
    spike_valid = 1'b0; spike_in = 8'h00;
    tests_run++;
    if (ev_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_lat_e0 got v=%0b want 0", ev_valid);
    end
    @(negedge clk);
    tests_run++;
    if (ev_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_lat_e1 got v=%0b want 0", ev_valid);
    end
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      if (sb_q.size() == 0) break;
      if (ev_valid && ev_ready) begin
        tests_run++;
        if (c != 3 - sb_q.size()) begin
          tests_failed++;
          $display("FAIL single_timing got cycle %0d want %0d", c, 3 - sb_q.size());
        end
        exp_w = sb_q.pop_front();
        tests_run++;
        if ({ev_ts, ev_addr} !== exp_w) begin
          tests_failed++;
          $display("FAIL single_event got ts=%0d addr=%0d want ts=%0d addr=%0d",
                   ev_ts, ev_addr, exp_w[7:3], exp_w[2:0]);
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if (sb_q.size() != 0 || busy !== 1'b0 || ev_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_end got pending=%0d busy=%0b v=%0b want 0 0 0", sb_q.size(), busy, ev_valid);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    ev_ready = 1'b0;
    spike_in = 8'hFF; spike_valid = 1'b1;
    @(negedge clk);
    spike_valid = 1'b0; spike_in = 8'h00;
    @(negedge clk);
    spike_in = 8'h0F; spike_valid = 1'b1;
    @(negedge clk);
    spike_valid = 1'b0; spike_in = 8'h00;
    repeat (12) @(negedge clk);
    tests_run++;
    if (drop_cnt !== 8'd1 || overflow !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_drop got drop=%0d ovf=%0b busy=%0b want 1 1 1", drop_cnt, overflow, busy);
    end
    for (int c = 0; c < 4; c++) begin
      tests_run++;
      if (ev_valid !== 1'b1 || {ev_ts, ev_addr} !== 8'h00) begin
        tests_failed++;
        $display("FAIL bp_stable got v=%0b ts=%0d addr=%0d want v=1 ts=0 addr=0", ev_valid, ev_ts, ev_addr);
      end
      @(negedge clk);
    end
    for (int a = 0; a < 8; a++) begin
      sb_q.push_back({5'd0, 3'(a)});
    end
    ev_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (sb_q.size() == 0) break;
      if (ev_valid && ev_ready) begin
        exp_w = sb_q.pop_front();
        tests_run++;
        if ({ev_ts, ev_addr} !== exp_w) begin
          tests_failed++;
          $display("FAIL bp_event got ts=%0d addr=%0d want ts=%0d addr=%0d",
                   ev_ts, ev_addr, exp_w[7:3], exp_w[2:0]);
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if (sb_q.size() != 0 || ev_valid !== 1'b0 || overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_end got pending=%0d v=%0b ovf=%0b want 0 0 1", sb_q.size(), ev_valid, overflow);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    ev_ready = 1'b1;
    spike_in = 8'h01; spike_valid = 1'b1;
    sb_q.push_back({5'd0, 3'd0});
    @(negedge clk);
    spike_in = 8'h80;
    sb_q.push_back({5'd1, 3'd7});
    @(negedge clk);
    spike_valid = 1'b0; spike_in = 8'h00;
    for (int c = 0; c < 20; c++) begin
      if (sb_q.size() == 0) break;
      if (ev_valid && ev_ready) begin
        exp_w = sb_q.pop_front();
        tests_run++;
        if ({ev_ts, ev_addr} !== exp_w) begin
          tests_failed++;
          $display("FAIL b2b_event got ts=%0d addr=%0d want ts=%0d addr=%0d",
                   ev_ts, ev_addr, exp_w[7:3], exp_w[2:0]);
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if (sb_q.size() != 0 || drop_cnt !== 8'd0 || overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_end got pending=%0d drop=%0d ovf=%0b want 0 0 0", sb_q.size(), drop_cnt, overflow);
    end
  endtask

  task automatic test_zero_wrap();
    apply_reset();
    ev_ready = 1'b1;
    spike_in = 8'h00; spike_valid = 1'b1;
    repeat (33) @(negedge clk);
    spike_in = 8'h10;
    sb_q.push_back({5'd1, 3'd4});
    @(negedge clk);
    spike_valid = 1'b0; spike_in = 8'h00;
    for (int c = 0; c < 20; c++) begin
      if (sb_q.size() == 0) break;
      if (ev_valid && ev_ready) begin
        exp_w = sb_q.pop_front();
        tests_run++;
        if ({ev_ts, ev_addr} !== exp_w) begin
          tests_failed++;
          $display("FAIL wrap_event got ts=%0d addr=%0d want ts=%0d addr=%0d",
                   ev_ts, ev_addr, exp_w[7:3], exp_w[2:0]);
        end
      end
      @(negedge clk);
    end
    tests_run++;
    if (sb_q.size() != 0 || ev_valid !== 1'b0 || drop_cnt !== 8'd0) begin
      tests_failed++;
      $display("FAIL wrap_end got pending=%0d v=%0b drop=%0d want 0 0 0", sb_q.size(), ev_valid, drop_cnt);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    ev_ready = 1'b0;
    spike_in = 8'hFF; spike_valid = 1'b1;
    repeat (310) @(negedge clk);
    tests_run++;
    if (drop_cnt !== 8'd255 || overflow !== 1'b1) begin
      tests_failed++;
      $display("FAIL sat_reach got drop=%0d ovf=%0b want 255 1", drop_cnt, overflow);
    end
    repeat (20) @(negedge clk);
    tests_run++;
    if (drop_cnt !== 8'd255) begin
      tests_failed++;
      $display("FAIL sat_hold got drop=%0d want 255", drop_cnt);
    end
    spike_valid = 1'b0; spike_in = 8'h00;
  endtask

  initial begin
    rst_n = 1'b0;
    spike_in = 8'h00;
    spike_valid = 1'b0;
    ev_ready = 1'b0;
    test_reset();
    test_single_frame();
    test_backpressure();
    test_back_to_back();
    test_zero_wrap();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
